// File: rtl/morse_sender.sv
// ---------------------------------------------------------------------------
// morse_sender
//
// Serialises the Morse code of one letter (A..H) onto a single LED level,
// advancing one Morse time unit for every Tick pulse from the rate divider.
//
// Parameters
//   PATTERN_W  width of the pattern shift register (>= 11)
//   LEN_W      width of the remaining-length counter (must hold PATTERN_W)
//
// Ports
//   ClockIn      system clock
//   Reset        synchronous, active-high reset
//   Tick         one-cycle enable; one Morse time unit per Tick
//   Start        send request, level-sampled while idle
//   Letter       letter select, 0=A .. 7=H, sampled on the Start edge only
//   MorseOut     serial Morse level, 1 = LED on (registered)
//   Busy         high while a letter is in progress (registered)
//   Done         one-cycle pulse when a letter completes (registered)
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: Start is a level request accepted only in IDLE; Busy rises on
// the accepting edge and falls on the same edge Done pulses. Start seen while
// Busy is ignored.
//
// Optional build macro: MORSE_SENDER_REPEAT_EN
//   When defined, holding Start through the end of a letter inserts a
//   3-unit inter-letter gap and then resends the letter currently on Letter,
//   keeping Busy high. Done pulses once per letter.
// ---------------------------------------------------------------------------
module morse_sender #(
   parameter int PATTERN_W = 12,
   parameter int LEN_W     = 4
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic       Tick,
   input  logic       Start,
   input  logic [2:0] Letter,
   output logic       MorseOut,
   output logic       Busy,
   output logic       Done,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_SEND  = 3'd2,
      S_TAIL  = 3'd3
`ifdef MORSE_SENDER_REPEAT_EN
      ,
      S_GAP   = 3'd4
`endif
   } state_t;

   state_t               r_state;
   logic [PATTERN_W-1:0] r_shift;
   logic [LEN_W-1:0]     r_len;
   logic                 r_morse;
   logic                 r_busy;
   logic                 r_done;

   state_t               w_state_nx;
   logic [PATTERN_W-1:0] w_shift_nx;
   logic [LEN_W-1:0]     w_len_nx;
   logic                 w_morse_nx;
   logic                 w_busy_nx;
   logic                 w_done_nx;

   // Pattern ROM: LSB is the first unit transmitted, upper bits zero.
   function automatic logic [PATTERN_W-1:0] f_pattern(input logic [2:0] letter);
      logic [PATTERN_W-1:0] pat;
      case (letter)
         3'd0:    pat = PATTERN_W'(11'b000_0001_1101); // A 10111
         3'd1:    pat = PATTERN_W'(11'b001_0101_0111); // B 111010101
         3'd2:    pat = PATTERN_W'(11'b101_1101_0111); // C 11101011101
         3'd3:    pat = PATTERN_W'(11'b000_0101_0111); // D 1110101
         3'd4:    pat = PATTERN_W'(11'b000_0000_0001); // E 1
         3'd5:    pat = PATTERN_W'(11'b001_0111_0101); // F 101011101
         3'd6:    pat = PATTERN_W'(11'b001_0111_0111); // G 111011101
         default: pat = PATTERN_W'(11'b000_0101_0101); // H 1010101
      endcase
      return pat;
   endfunction

   function automatic logic [LEN_W-1:0] f_length(input logic [2:0] letter);
      logic [LEN_W-1:0] len;
      case (letter)
         3'd0:    len = LEN_W'(5);
         3'd1:    len = LEN_W'(9);
         3'd2:    len = LEN_W'(11);
         3'd3:    len = LEN_W'(7);
         3'd4:    len = LEN_W'(1);
         3'd5:    len = LEN_W'(9);
         3'd6:    len = LEN_W'(9);
         default: len = LEN_W'(7);
      endcase
      return len;
   endfunction

   // State and all outputs are registered, so nothing reaches the outputs
   // combinationally from the inputs.
   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_len   <= '0;
         r_morse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_shift <= w_shift_nx;
         r_len   <= w_len_nx;
         r_morse <= w_morse_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_len_nx   = r_len;
      w_morse_nx = r_morse;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_morse_nx = 1'b0;
            w_busy_nx  = 1'b0;
            if (Start) begin
               w_shift_nx = f_pattern(Letter);
               w_len_nx   = f_length(Letter);
               w_busy_nx  = 1'b1;
               w_state_nx = S_ARMED;
            end
         end

         // Entered on the Start edge, so a Tick on that same edge is never
         // seen here; the first unit goes out on the following Tick.
         S_ARMED: begin
            if (Tick) begin
               w_morse_nx = r_shift[0];
               w_shift_nx = r_shift >> 1;
               w_len_nx   = r_len - LEN_W'(1);
               w_state_nx = S_SEND;
            end
         end

         // The Tick that finds length==0 is the one that ends the last unit,
         // so every unit, including the last, lasts a full Tick period.
         S_SEND: begin
            if (Tick) begin
               if (r_len != '0) begin
                  w_morse_nx = r_shift[0];
                  w_shift_nx = r_shift >> 1;
                  w_len_nx   = r_len - LEN_W'(1);
               end else begin
                  w_morse_nx = 1'b0;
`ifdef MORSE_SENDER_REPEAT_EN
                  if (Start) begin
                     // This Tick is gap unit 1; r_len now counts the
                     // remaining gap units before the gap-end Tick.
                     w_len_nx   = LEN_W'(1);
                     w_state_nx = S_GAP;
                  end else begin
                     w_state_nx = S_TAIL;
                  end
`else
                  w_state_nx = S_TAIL;
`endif
               end
            end
         end

         S_TAIL: begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = S_IDLE;
         end

`ifdef MORSE_SENDER_REPEAT_EN
         // Gap units 2 and 3. On the gap-end Tick the previous letter is
         // complete: either reload and rearm (Done pulses here) or finish
         // through TAIL (which pulses Done itself).
         S_GAP: begin
            w_morse_nx = 1'b0;
            if (Tick) begin
               if (r_len != '0) begin
                  w_len_nx = r_len - LEN_W'(1);
               end else if (Start) begin
                  w_shift_nx = f_pattern(Letter);
                  w_len_nx   = f_length(Letter);
                  w_done_nx  = 1'b1;
                  w_state_nx = S_ARMED;
               end else begin
                  w_state_nx = S_TAIL;
               end
            end
         end
`endif

         default: begin
            w_morse_nx = 1'b0;
            w_busy_nx  = 1'b0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign MorseOut    = r_morse;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_morse_sender.sv
module tb_morse_sender;

   logic       ClockIn;
   logic       Reset;
   logic       Tick;
   logic       Start;
   logic [2:0] Letter;
   logic       MorseOut;
   logic       Busy;
   logic       Done;
   logic [2:0] o_dbg_state;

   int total = 0;
   int bad   = 0;

   morse_sender #(
      .PATTERN_W (12),
      .LEN_W     (4)
   ) dut (
      .ClockIn     (ClockIn),
      .Reset       (Reset),
      .Tick        (Tick),
      .Start       (Start),
      .Letter      (Letter),
      .MorseOut    (MorseOut),
      .Busy        (Busy),
      .Done        (Done),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock ----------------
   initial ClockIn = 1'b0;
   always #5 ClockIn = ~ClockIn;

   // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge ClockIn);
      #1;
   endtask

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   // pat is written as transmitted, first unit in the MSB of the len-bit field.
   typedef struct {
      string      name;
      logic [2:0] letter;
      int         gap;           // clocks between Ticks (1 = Tick every clock)
      bit         tick_at_start; // Tick asserted on the Start edge as well
      logic [10:0] pat;
      int         len;
      int         disturb;       // Tick index at which Letter=7/Start are pulsed, -1 none
   } vec_t;

   vec_t vecs[$];

   task automatic run_letter(input vec_t v);
      logic exp_bit;
      logic prev;
      prev   = 1'b0;
      Letter = v.letter;
      Start  = 1'b1;
      Tick   = v.tick_at_start;
      step();
      Start  = 1'b0;
      Tick   = 1'b0;
      chk({v.name, "/busy_at_start"}, {2'b0, Busy}, 3'd1);
      chk({v.name, "/morse_at_start"}, {2'b0, MorseOut}, 3'd0);
      for (int k = 0; k <= v.len; k++) begin
         for (int w = 1; w < v.gap; w++) begin
            step();
            chk({v.name, "/hold"}, {2'b0, MorseOut}, {2'b0, prev});
            chk({v.name, "/done_low"}, {2'b0, Done}, 3'd0);
         end
         Tick = 1'b1;
         if (k == v.disturb) begin
            Start  = 1'b1;
            Letter = 3'd7;
         end
         step();
         Tick  = 1'b0;
         Start = 1'b0;
         exp_bit = (k < v.len) ? v.pat[v.len - 1 - k] : 1'b0;
         chk({v.name, "/bit"}, {2'b0, MorseOut}, {2'b0, exp_bit});
         chk({v.name, "/busy"}, {2'b0, Busy}, 3'd1);
         chk({v.name, "/done_low"}, {2'b0, Done}, 3'd0);
         prev = exp_bit;
      end
      step();
      chk({v.name, "/done_pulse"}, {2'b0, Done}, 3'd1);
      chk({v.name, "/busy_end"}, {2'b0, Busy}, 3'd0);
      chk({v.name, "/morse_end"}, {2'b0, MorseOut}, 3'd0);
      step();
      chk({v.name, "/done_once"}, {2'b0, Done}, 3'd0);
      chk({v.name, "/idle_busy"}, {2'b0, Busy}, 3'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [10:0] c_pat;

      vecs.push_back('{"A_gap4",      3'd0, 4, 1'b0, 11'b10111,       5, -1});
      vecs.push_back('{"B_gap2",      3'd1, 2, 1'b0, 11'b111010101,   9, -1});
      vecs.push_back('{"C_disturbed", 3'd2, 2, 1'b0, 11'b11101011101, 11, 4});
      vecs.push_back('{"D_tickstart", 3'd3, 3, 1'b1, 11'b1110101,     7, -1});
      vecs.push_back('{"E_tiedhigh",  3'd4, 1, 1'b1, 11'b1,           1, -1});
      vecs.push_back('{"F_gap2",      3'd5, 2, 1'b0, 11'b101011101,   9, -1});
      vecs.push_back('{"G_tiedhigh",  3'd6, 1, 1'b0, 11'b111011101,   9, -1});
      vecs.push_back('{"H_gap3",      3'd7, 3, 1'b0, 11'b1010101,     7, -1});

      Reset  = 1'b1;
      Tick   = 1'b0;
      Start  = 1'b0;
      Letter = 3'd0;
      step();
      step();
      chk("reset/morse", {2'b0, MorseOut}, 3'd0);
      chk("reset/busy",  {2'b0, Busy}, 3'd0);
      chk("reset/done",  {2'b0, Done}, 3'd0);
      chk("reset/state", o_dbg_state, 3'd0);
      Reset = 1'b0;
      step();

      foreach (vecs[i]) run_letter(vecs[i]);

      // Reset on the 5th Tick of C, then no leftover units, then D sends cleanly.
      c_pat  = 11'b11101011101;
      Letter = 3'd2;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         Tick = 1'b1;
         step();
         Tick = 1'b0;
         chk("c_reset/pre_bit", {2'b0, MorseOut}, {2'b0, c_pat[10 - k]});
      end
      step();
      Tick  = 1'b1;
      Reset = 1'b1;
      step();
      Tick  = 1'b0;
      Reset = 1'b0;
      chk("c_reset/morse", {2'b0, MorseOut}, 3'd0);
      chk("c_reset/busy",  {2'b0, Busy}, 3'd0);
      chk("c_reset/done",  {2'b0, Done}, 3'd0);
      chk("c_reset/state", o_dbg_state, 3'd0);
      for (int k = 0; k < 6; k++) begin
         Tick = k[0];
         step();
         chk("c_reset/quiet_morse", {2'b0, MorseOut}, 3'd0);
         chk("c_reset/quiet_busy",  {2'b0, Busy}, 3'd0);
      end
      Tick = 1'b0;
      run_letter(vecs[3]);

      // Tick absent: the current level holds indefinitely.
      Letter = 3'd4;
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      Tick   = 1'b1;
      step();
      Tick   = 1'b0;
      chk("stall/first", {2'b0, MorseOut}, 3'd1);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("stall/hold", {2'b0, MorseOut}, 3'd1);
         chk("stall/busy", {2'b0, Busy}, 3'd1);
      end
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      chk("stall/off", {2'b0, MorseOut}, 3'd0);
      step();
      chk("stall/done", {2'b0, Done}, 3'd1);
      step();
      chk("stall/done_low", {2'b0, Done}, 3'd0);

`ifndef MORSE_SENDER_REPEAT_EN
      // Start held high with Tick tied high: E, TAIL, then retrigger.
      Letter = 3'd4;
      Start  = 1'b1;
      Tick   = 1'b1;
      step();
      chk("hold/busy0", {2'b0, Busy}, 3'd1);
      step();
      chk("hold/on", {2'b0, MorseOut}, 3'd1);
      step();
      chk("hold/off", {2'b0, MorseOut}, 3'd0);
      chk("hold/busy_tail", {2'b0, Busy}, 3'd1);
      step();
      chk("hold/done", {2'b0, Done}, 3'd1);
      chk("hold/busy_gap", {2'b0, Busy}, 3'd0);
      step();
      chk("hold/retrig_busy", {2'b0, Busy}, 3'd1);
      chk("hold/retrig_done", {2'b0, Done}, 3'd0);
      chk("hold/retrig_state", o_dbg_state, 3'd1);
      step();
      chk("hold/on2", {2'b0, MorseOut}, 3'd1);
      Start = 1'b0;
      step();
      chk("hold/off2", {2'b0, MorseOut}, 3'd0);
      step();
      chk("hold/done2", {2'b0, Done}, 3'd1);
      step();
      chk("hold/idle_busy", {2'b0, Busy}, 3'd0);
      Tick = 1'b0;
`else
      // Repeat: E with Start held and Tick tied high gives 1,0,0,0 per letter.
      begin
         logic [7:0] exp_m;
         logic [7:0] exp_d;
         exp_m = 8'b1000_1000; // MSB = first Tick
         exp_d = 8'b0001_0001;
         Letter = 3'd4;
         Start  = 1'b1;
         Tick   = 1'b1;
         step();
         for (int k = 0; k < 8; k++) begin
            step();
            chk("rep/morse", {2'b0, MorseOut}, {2'b0, exp_m[7 - k]});
            chk("rep/done",  {2'b0, Done}, {2'b0, exp_d[7 - k]});
            chk("rep/busy",  {2'b0, Busy}, 3'd1);
         end
         Start = 1'b0;
         step();
         chk("rep/last_on", {2'b0, MorseOut}, 3'd1);
         step();
         chk("rep/last_off", {2'b0, MorseOut}, 3'd0);
         step();
         chk("rep/final_done", {2'b0, Done}, 3'd1);
         chk("rep/final_busy", {2'b0, Busy}, 3'd0);
         Tick = 1'b0;
         step();
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
